// File: rtl/wb_arbiter.sv
// Write-back port arbiter: shares the register-file write port between execute
// results and in-order load returns, tracking outstanding loads for hazard stalls.
`timescale 1ns/1ps

module wb_arbiter #(
  parameter int LD_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [2:0]  ex_rd_i,
  input  logic [15:0] ex_data_i,
  output logic        ex_ready_o,
  input  logic        ld_issue_i,
  input  logic [2:0]  ld_rd_i,
  output logic        ld_ready_o,
  input  logic        mem_valid_i,
  input  logic [15:0] mem_data_i,
  output logic        rf_we_o,
  output logic [2:0]  rf_waddr_o,
  output logic [15:0] rf_wdata_o,
  output logic [7:0]  pending_o,
  output logic        err_o
);

  localparam logic [0:0] HOLD_EMPTY = 1'b0;
  localparam logic [0:0] HOLD_FULL  = 1'b1;
  localparam logic [1:0] DEPTH      = 2'(LD_DEPTH);

  logic [0:0]  holdState_q, holdState_d;
  logic [2:0]  holdRd_q, holdRd_d;
  logic [15:0] holdData_q, holdData_d;

  logic [2:0]  fifoRd_q [LD_DEPTH];
  logic        rdPtr_q, wrPtr_q;
  logic [1:0]  count_q, count_d;

  logic        rfWe_q, rfWe_d;
  logic [2:0]  rfWaddr_q, rfWaddr_d;
  logic [15:0] rfWdata_q, rfWdata_d;
  logic        err_q, err_d;

  logic        holdFull;
  logic        memPop;
  logic        exAccept;
  logic        ldPush;
  logic [2:0]  headRd;
  logic [7:0]  pendingMask;
  logic        winValid;
  logic [2:0]  winRd;
  logic [15:0] winData;

  assign holdFull = (holdState_q == HOLD_FULL);
  assign headRd   = fifoRd_q[rdPtr_q];
  assign memPop   = mem_valid_i && (count_q != 2'd0);

  // Valid FIFO entries decoded one-hot; r0 can never be a hazard.
  always_comb begin
    pendingMask = '0;
    if (count_q != 2'd0) pendingMask[fifoRd_q[rdPtr_q]] = 1'b1;
    if (count_q == 2'd2) pendingMask[fifoRd_q[~rdPtr_q]] = 1'b1;
    pendingMask[0] = 1'b0;
  end

  assign ex_ready_o = !holdFull && !pendingMask[ex_rd_i];
  assign ld_ready_o = (count_q < DEPTH) && !(holdFull && (holdRd_q == ld_rd_i));
  assign exAccept   = ex_valid_i && ex_ready_o;
  assign ldPush     = ld_issue_i && ld_ready_o;

  // Port winner: load return, then parked result, then fresh execute result.
  always_comb begin
    holdState_d = holdState_q;
    holdRd_d    = holdRd_q;
    holdData_d  = holdData_q;
    winValid    = 1'b0;
    winRd       = rfWaddr_q;
    winData     = rfWdata_q;
    if (memPop) begin
      winValid = 1'b1;
      winRd    = headRd;
      winData  = mem_data_i;
      if (exAccept) begin
        holdState_d = HOLD_FULL;
        holdRd_d    = ex_rd_i;
        holdData_d  = ex_data_i;
      end
    end else if (holdFull) begin
      winValid    = 1'b1;
      winRd       = holdRd_q;
      winData     = holdData_q;
      holdState_d = HOLD_EMPTY;
    end else if (exAccept) begin
      winValid = 1'b1;
      winRd    = ex_rd_i;
      winData  = ex_data_i;
    end
    rfWe_d    = winValid && (winRd != 3'd0);
    rfWaddr_d = winRd;
    rfWdata_d = winData;
  end

  always_comb begin
    count_d = count_q;
    if (ldPush && !memPop)      count_d = count_q + 2'd1;
    else if (!ldPush && memPop) count_d = count_q - 2'd1;
    err_d = err_q || (mem_valid_i && (count_q == 2'd0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      holdState_q <= HOLD_EMPTY;
      holdRd_q    <= '0;
      holdData_q  <= '0;
      for (int i = 0; i < LD_DEPTH; i++) fifoRd_q[i] <= '0;
      rdPtr_q     <= 1'b0;
      wrPtr_q     <= 1'b0;
      count_q     <= '0;
      rfWe_q      <= 1'b0;
      rfWaddr_q   <= '0;
      rfWdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      holdState_q <= holdState_d;
      holdRd_q    <= holdRd_d;
      holdData_q  <= holdData_d;
      if (ldPush) begin
        fifoRd_q[wrPtr_q] <= ld_rd_i;
        wrPtr_q           <= ~wrPtr_q;
      end
      if (memPop) rdPtr_q <= ~rdPtr_q;
      count_q     <= count_d;
      rfWe_q      <= rfWe_d;
      rfWaddr_q   <= rfWaddr_d;
      rfWdata_q   <= rfWdata_d;
      err_q       <= err_d;
    end
  end

  assign rf_we_o    = rfWe_q;
  assign rf_waddr_o = rfWaddr_q;
  assign rf_wdata_o = rfWdata_q;
  assign pending_o  = pendingMask;
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model feeds a
// write scoreboard that an independent monitor drains on every rf write.
`timescale 1ns/1ps

module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        exValid = 1'b0;
  logic [2:0]  exRd = '0;
  logic [15:0] exData = '0;
  logic        exReady;
  logic        ldIssue = 1'b0;
  logic [2:0]  ldRd = '0;
  logic        ldReady;
  logic        memValid = 1'b0;
  logic [15:0] memData = '0;
  logic        rfWe;
  logic [2:0]  rfWaddr;
  logic [15:0] rfWdata;
  logic [7:0]  pending;
  logic        err;

  wb_arbiter #(.LD_DEPTH(2)) dut (
    .clk_i(clock), .rst_i(rst),
    .ex_valid_i(exValid), .ex_rd_i(exRd), .ex_data_i(exData), .ex_ready_o(exReady),
    .ld_issue_i(ldIssue), .ld_rd_i(ldRd), .ld_ready_o(ldReady),
    .mem_valid_i(memValid), .mem_data_i(memData),
    .rf_we_o(rfWe), .rf_waddr_o(rfWaddr), .rf_wdata_o(rfWdata),
    .pending_o(pending), .err_o(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [2:0]  rd;
    logic [15:0] data;
  } wr_t;

  wr_t         expQ[$];
  logic [2:0]  loadQ[$];
  logic        holdM = 1'b0;
  logic [2:0]  holdRdM = '0;
  logic [15:0] holdDataM = '0;
  logic        errM = 1'b0;

  int cycleCnt = 0;
  int assertCount = 0;
  int failCount = 0;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  function automatic logic [7:0] modelPending();
    logic [7:0] m = '0;
    foreach (loadQ[i]) if (loadQ[i] != 3'd0) m[loadQ[i]] = 1'b1;
    return m;
  endfunction

  task automatic expectWrite(input logic [2:0] rd, input logic [15:0] data);
    wr_t e;
    if (rd != 3'd0) begin
      e.cyc  = cycleCnt + 1;
      e.rd   = rd;
      e.data = data;
      expQ.push_back(e);
    end
  endtask

  // One cycle of stimulus: drive, compare combinational outputs, advance model.
  task automatic applyStimulus(input logic exV, input logic [2:0] eRd, input logic [15:0] eData,
                               input logic ldI, input logic [2:0] lRd,
                               input logic memV, input logic [15:0] mData);
    logic [7:0] pendM;
    logic       exRdyM, ldRdyM, exAcc, ldAcc;
    wr_t        h;
    @(negedge clock);
    exValid = exV; exRd = eRd; exData = eData;
    ldIssue = ldI; ldRd = lRd;
    memValid = memV; memData = mData;
    #1;
    pendM  = modelPending();
    exRdyM = !holdM && !pendM[eRd];
    ldRdyM = (loadQ.size() < 2) && !(holdM && holdRdM == lRd);
    checkOutput("ex_ready", 32'(exReady), 32'(exRdyM));
    checkOutput("ld_ready", 32'(ldReady), 32'(ldRdyM));
    checkOutput("pending", 32'(pending), 32'(pendM));
    checkOutput("err", 32'(err), 32'(errM));
    exAcc = exV && exRdyM;
    ldAcc = ldI && ldRdyM;
    if (memV && loadQ.size() == 0) errM = 1'b1;
    if (memV && loadQ.size() > 0) begin
      expectWrite(loadQ.pop_front(), mData);
      if (exAcc) begin
        holdM = 1'b1; holdRdM = eRd; holdDataM = eData;
      end
    end else if (holdM) begin
      expectWrite(holdRdM, holdDataM);
      holdM = 1'b0;
    end else if (exAcc) begin
      expectWrite(eRd, eData);
    end
    if (ldAcc) loadQ.push_back(lRd);
    h.cyc = 0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0);
  endtask

  task automatic doReset();
    @(negedge clock);
    exValid = 1'b0; ldIssue = 1'b0; memValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_we", 32'(rfWe), 32'h0);
    checkOutput("rst_waddr", 32'(rfWaddr), 32'h0);
    checkOutput("rst_wdata", 32'(rfWdata), 32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    loadQ.delete();
    expQ.delete();
    holdM = 1'b0;
    errM = 1'b0;
    @(negedge clock);
    rst = 1'b0;
  endtask

  // Monitor: every rf write must match the oldest expected write and its cycle.
  always @(negedge clock) begin
    if (!rst) begin
      while (expQ.size() > 0 && expQ[0].cyc < cycleCnt) begin
        checkOutput("write_missing_rd", 32'(rfWe ? rfWaddr : 3'd0), 32'(expQ[0].rd));
        void'(expQ.pop_front());
      end
      if (rfWe) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", 32'(rfWaddr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("write_cycle", 32'(cycleCnt), 32'(e.cyc));
          checkOutput("write_addr", 32'(rfWaddr), 32'(e.rd));
          checkOutput("write_data", 32'(rfWdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();

    // Uncontested execute
    applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 16'h0);
    idle();
    checkOutput("ex_we", 32'(rfWe), 32'h1);
    checkOutput("ex_waddr", 32'(rfWaddr), 32'h3);
    checkOutput("ex_wdata", 32'(rfWdata), 32'h1234);

    // Load round trip
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 16'h0);
    idle();
    checkOutput("pending_r5", 32'(pending), 32'h20);
    idle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 16'hBEEF);
    idle();
    checkOutput("ld_waddr", 32'(rfWaddr), 32'h5);
    checkOutput("ld_wdata", 32'(rfWdata), 32'hBEEF);
    checkOutput("pending_clr", 32'(pending), 32'h0);

    // Collision
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 16'h0);
    idle();
    applyStimulus(1'b1, 3'd4, 16'h0055, 1'b0, 3'd0, 1'b1, 16'h00AA);
    idle();
    checkOutput("col1_waddr", 32'(rfWaddr), 32'h2);
    checkOutput("col1_wdata", 32'(rfWdata), 32'h00AA);
    checkOutput("col1_exrdy", 32'(exReady), 32'h0);
    idle();
    checkOutput("col2_waddr", 32'(rfWaddr), 32'h4);
    checkOutput("col2_wdata", 32'(rfWdata), 32'h0055);
    checkOutput("col2_exrdy", 32'(exReady), 32'h1);

    // FIFO full and WAW stall
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 16'h0);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0, 16'h0);
    applyStimulus(1'b1, 3'd6, 16'h6666, 1'b1, 3'd7, 1'b0, 16'h0);
    checkOutput("full_ldrdy", 32'(ldReady), 32'h0);
    checkOutput("full_pending", 32'(pending), 32'h42);
    checkOutput("waw_exrdy", 32'(exReady), 32'h0);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 16'h1111);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 16'h6060);
    idle();
    idle();

    // r0 writes and error flag
    applyStimulus(1'b1, 3'd0, 16'h7777, 1'b0, 3'd0, 1'b0, 16'h0);
    idle();
    checkOutput("r0_we", 32'(rfWe), 32'h0);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 16'hDEAD);
    idle();
    checkOutput("err_set", 32'(err), 32'h1);
    checkOutput("err_nowrite", 32'(rfWe), 32'h0);
    idle();
    doReset();

    // Reset with parked result and outstanding load
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 16'h0);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 16'h0);
    applyStimulus(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 1'b1, 16'hAAAA);
    doReset();
    idle();
    idle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 16'h5555);
    idle();
    checkOutput("late_ret_err", 32'(err), 32'h1);
    doReset();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic memV;
      memV = (loadQ.size() > 0) && ($urandom_range(0, 2) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                    memV, 16'($urandom));
      if ($urandom_range(0, 399) == 0) doReset();
    end

    // Drain
    for (int i = 0; i < 4 && loadQ.size() > 0; i++)
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 16'($urandom));
    idle();
    idle();
    idle();
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back port arbiter for the 16-bit core. It shares the single register-file write port between the execute-stage result (ALU or PC+imm, already selected upstream) and variable-latency load returns from data memory. It tracks outstanding loads in a 2-entry destination FIFO and exports a per-register pending mask for hazard stalls. Load returns always win the port; colliding execute results are parked in a 1-entry hold buffer.

## Interface
Parameters:
- LD_DEPTH, 2, max outstanding loads (destination FIFO depth; fixed at 2 for this revision)

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- ex_valid_i  in  1  execute result offered
- ex_rd_i  in  3  execute destination register
- ex_data_i  in  16  execute result (ALU or PC+imm)
- ex_ready_o  out  1  execute result accepted this cycle when valid&ready
- ld_issue_i  in  1  load issued to memory
- ld_rd_i  in  3  load destination register
- ld_ready_o  out  1  load issue accepted when issue&ready
- mem_valid_i  in  1  load data returned (in issue order, cannot be stalled)
- mem_data_i  in  16  load data
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  3  register-file write address (registered)
- rf_wdata_o  out  16  register-file write data (registered)
- pending_o  out  8  bit n set while a load to rN is outstanding
- err_o  out  1  sticky: mem_valid_i with empty FIFO

## Operation
- Reset (async): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, hold buffer empty, FIFO empty (count 0, pointers 0), pending_o=0, err_o=0.
- Port winner each cycle, priority: (1) mem return, (2) hold buffer, (3) accepted execute result.
- Mem return: pops FIFO head rd; write {head rd, mem_data_i}.
- Execute handshake: ex_ready_o = !hold_full & !pending_o[ex_rd_i] (WAW stall; r0 never pending). Accepted result goes to port if no mem return and hold empty; else into hold buffer.
- Hold buffer states: EMPTY -> FULL when accepted result loses to mem return. FULL -> EMPTY when it wins the port (no mem return). ex_ready_o=0 while FULL, so FULL->FULL via accept is impossible.
- Load issue: ld_ready_o = (count<2) & !(hold_full & hold_rd==ld_rd_i). Accepted issue pushes ld_rd_i. Simultaneous push and pop allowed at any count<2; count unchanged.
- pending_o = OR of one-hot decode of valid FIFO entries; entries with rd=0 contribute nothing.
- r0 hardwired zero: any winning write with rd=0 consumes its slot/handshake but rf_we_o stays 0.
- mem_valid_i with count=0: ignored (no write, no pop), err_o set until reset.
- No mem return, hold empty, no accepted execute: rf_we_o=0; waddr/wdata hold last value.

## Timing
- Execute result, uncontested: rf_we_o in cycle after handshake (latency 1).
- Execute result contested: hold buffer, written first cycle with no mem return (latency >=2, unbounded under continuous returns).
- Load return: written cycle after mem_valid_i (latency 1).
- pending_o bit rises cycle after issue accept, falls cycle after matching mem_valid_i (same edge rf_we_o rises).
- ex_ready_o and ld_ready_o are combinational from state and current rd inputs; no dependence on ex_valid_i/ld_issue_i.
- Reset mid-operation: hold contents and outstanding loads discarded; late mem returns then flag err_o.

## Test plan
- Uncontested execute: ex_valid_i, rd=3, data=0x1234 -> next cycle rf_we_o=1, waddr=3, wdata=0x1234; ex_ready_o=1 throughout.
- Load round trip: issue rd=5, mem_valid_i 3 cycles later with 0xBEEF -> pending_o=0x20 from cycle+1 until return; write r5=0xBEEF cycle after return; pending_o=0.
- Collision: load to r2 outstanding; same cycle mem_valid_i(0x00AA) and execute r4=0x0055 -> cycle+1 writes r2=0x00AA, ex_ready_o=0; cycle+2 writes r4=0x0055, ex_ready_o=1.
- FIFO full/WAW: issue loads to r1, r6 -> ld_ready_o=0, pending_o=0x42; execute to r6 sees ex_ready_o=0; returns write r1 then r6 in order.
- r0 and error: execute rd=0 -> handshake completes, rf_we_o stays 0; mem_valid_i with empty FIFO -> no write, err_o=1 until rst_i.
- Async reset with hold FULL and count=2 -> all outputs zero immediately, no write of held data after reset release.
